// File: rtl/multi_dataflow_pkg.sv
// rtl/multi_dataflow_pkg.sv - shared width helpers for the multi-flux dataflow fabric
package multi_dataflow_pkg;

  // Number of tag bits needed to name one of 'flux' lanes; a single lane needs none.
  function automatic int tag_w(input int flux);
    return (flux > 1) ? $clog2(flux) : 0;
  endfunction

  // Token width: payload plus the flux tag carried in the MSBs.
  function automatic int token_w(input int data_w, input int flux);
    return data_w + tag_w(flux);
  endfunction

endpackage

// File: rtl/flux_fifo_lane.sv
// rtl/flux_fifo_lane.sv - single-lane first-word-fall-through FIFO with sticky error flags
module flux_fifo_lane #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;
  logic [CW-1:0]    count_nxt;

  // Accept decisions use the registered full/empty, so a full lane takes only
  // the pop and an empty lane takes only the push when both arrive together.
  always_comb begin
    wr_ok     = wr && !full;
    rd_ok     = rd && !empty;
    count_nxt = count;
    if (wr_ok && !rd_ok)
      count_nxt = count + CW'(1);
    else if (!wr_ok && rd_ok)
      count_nxt = count - CW'(1);
  end

  // Pointers, occupancy and sticky flags; full/empty are registered alongside count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      if (wr && full)
        ovf <= 1'b1;
      if (rd && empty)
        udf <= 1'b1;
    end
  end

  // Token storage; left unreset since empty masks stale contents.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok)
      mem[wr_ptr] <= din;
  end

  // Head of queue falls through; forced to zero while the lane is empty.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/flux_fifo.sv
// rtl/flux_fifo.sv - tagged token buffer steering writes into per-flux FWFT lanes
module flux_fifo
  import multi_dataflow_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int FLUX       = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [token_w(DATA_WIDTH, FLUX)-1:0]    din,
  input  logic                                    write,
  output logic [FLUX-1:0]                         full,
  output logic [FLUX*token_w(DATA_WIDTH, FLUX)-1:0] dout,
  input  logic [FLUX-1:0]                         read,
  output logic [FLUX-1:0]                         empty,
  output logic [FLUX*$clog2(DEPTH+1)-1:0]         count,
  output logic [FLUX-1:0]                         ovf,
  output logic [FLUX-1:0]                         udf
);

  localparam int TAG_W   = tag_w(FLUX);
  localparam int TOKEN_W = token_w(DATA_WIDTH, FLUX);
  localparam int CW      = $clog2(DEPTH+1);

  logic [FLUX-1:0] wr_vec;

  generate
    if (FLUX == 1) begin : g_single
      assign wr_vec = write;
    end else begin : g_multi
      logic [TAG_W-1:0] tag;
      assign tag = din[TOKEN_W-1 -: TAG_W];

      // One-hot write steer; a tag naming a non-existent lane matches nothing and is dropped.
      always_comb begin
        wr_vec = '0;
        for (int f = 0; f < FLUX; f++)
          if (write && (32'(tag) == 32'(f)))
            wr_vec[f] = 1'b1;
      end
    end
  endgenerate

  generate
    for (genvar f = 0; f < FLUX; f++) begin : g_lane
      flux_fifo_lane #(
        .WIDTH (TOKEN_W),
        .DEPTH (DEPTH)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr_vec[f]),
        .din   (din),
        .rd    (read[f]),
        .dout  (dout[f*TOKEN_W +: TOKEN_W]),
        .full  (full[f]),
        .empty (empty[f]),
        .count (count[f*CW +: CW]),
        .ovf   (ovf[f]),
        .udf   (udf[f])
      );
    end
  endgenerate

endmodule

// File: tb/tb_flux_fifo.sv
// tb/tb_flux_fifo.sv - vector table, corner sequences and randomized model check for flux_fifo
module tb_flux_fifo;

  localparam int DW    = 4;
  localparam int DEPTH = 4;
  localparam int FLUX  = 2;
  localparam int TW    = 5;
  localparam int CW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [TW-1:0]     din;
  logic              write;
  logic [FLUX-1:0]   full;
  logic [FLUX*TW-1:0] dout;
  logic [FLUX-1:0]   read;
  logic [FLUX-1:0]   empty;
  logic [FLUX*CW-1:0] count;
  logic [FLUX-1:0]   ovf;
  logic [FLUX-1:0]   udf;

  int total = 0;
  int bad   = 0;

  flux_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FLUX(FLUX)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .write (write),
    .full  (full),
    .dout  (dout),
    .read  (read),
    .empty (empty),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per flux plus sticky flags.
  logic [TW-1:0] q [FLUX][$];
  logic [FLUX-1:0] m_ovf;
  logic [FLUX-1:0] m_udf;

  typedef struct {
    logic        wr;
    logic [4:0]  d;
    logic [1:0]  rd;
    logic [1:0]  e_empty;
    logic [1:0]  e_full;
    logic [2:0]  e_c0;
    logic [2:0]  e_c1;
    logic [1:0]  e_ovf;
    logic [1:0]  e_udf;
    logic [1:0]  mask;
    logic [9:0]  e_dout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic w, input logic [4:0] d, input logic [1:0] r, input logic rs);
    logic [FLUX-1:0] was_full;
    logic [FLUX-1:0] was_empty;
    int f;
    if (rs) begin
      for (int l = 0; l < FLUX; l++) q[l].delete();
      m_ovf = '0;
      m_udf = '0;
      return;
    end
    for (int l = 0; l < FLUX; l++) begin
      was_full[l]  = (q[l].size() == DEPTH);
      was_empty[l] = (q[l].size() == 0);
    end
    for (int l = 0; l < FLUX; l++)
      if (r[l]) begin
        if (was_empty[l]) m_udf[l] = 1'b1;
        else void'(q[l].pop_front());
      end
    if (w) begin
      f = int'(d[4]);
      if (was_full[f]) m_ovf[f] = 1'b1;
      else q[f].push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    for (int l = 0; l < FLUX; l++) begin
      chk({tag, "_empty"}, 32'(empty[l]), 32'(q[l].size() == 0));
      chk({tag, "_full"},  32'(full[l]),  32'(q[l].size() == DEPTH));
      chk({tag, "_count"}, 32'(count[l*CW +: CW]), 32'(q[l].size()));
      chk({tag, "_ovf"},   32'(ovf[l]), 32'(m_ovf[l]));
      chk({tag, "_udf"},   32'(udf[l]), 32'(m_udf[l]));
      if (q[l].size() != 0)
        chk({tag, "_dout"}, 32'(dout[l*TW +: TW]), 32'(q[l][0]));
    end
  endtask

  task automatic step(input logic w, input logic [4:0] d, input logic [1:0] r, input logic rs);
    write = w;
    din   = d;
    read  = r;
    rst   = rs;
    @(posedge clk);
    model_update(w, d, r, rs);
    #1;
    write = 1'b0;
    read  = '0;
    rst   = 1'b0;
  endtask

  task automatic add(input logic wr, input logic [4:0] d, input logic [1:0] rd,
                     input logic [1:0] e_empty, input logic [1:0] e_full,
                     input logic [2:0] e_c0, input logic [2:0] e_c1,
                     input logic [1:0] e_ovf, input logic [1:0] e_udf,
                     input logic [1:0] mask, input logic [9:0] e_dout);
    vec_t v;
    v.wr = wr; v.d = d; v.rd = rd; v.e_empty = e_empty; v.e_full = e_full;
    v.e_c0 = e_c0; v.e_c1 = e_c1; v.e_ovf = e_ovf; v.e_udf = e_udf;
    v.mask = mask; v.e_dout = e_dout;
    tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; write = 1'b0; read = '0; din = '0;
    m_ovf = '0; m_udf = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_empty", 32'(empty), 32'h3);
    chk("reset_full",  32'(full),  32'h0);
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_ovf",   32'(ovf),   32'h0);
    chk("reset_udf",   32'(udf),   32'h0);
    chk("reset_dout",  32'(dout),  32'h0);

    //   wr  din        rd     empty  full   c0 c1 ovf    udf    mask   dout {lane1,lane0}
    add(0, 5'b00000, 2'b00, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, {5'b00000, 5'b00000});
    add(1, 5'b00011, 2'b00, 2'b10, 2'b00, 1, 0, 2'b00, 2'b00, 2'b01, {5'b00000, 5'b00011});
    add(1, 5'b10101, 2'b00, 2'b00, 2'b00, 1, 1, 2'b00, 2'b00, 2'b11, {5'b10101, 5'b00011});
    add(0, 5'b00000, 2'b11, 2'b11, 2'b00, 0, 0, 2'b00, 2'b00, 2'b00, {5'b00000, 5'b00000});
    add(1, 5'b00001, 2'b00, 2'b10, 2'b00, 1, 0, 2'b00, 2'b00, 2'b01, {5'b00000, 5'b00001});
    add(1, 5'b00010, 2'b00, 2'b10, 2'b00, 2, 0, 2'b00, 2'b00, 2'b01, {5'b00000, 5'b00001});
    add(1, 5'b00011, 2'b00, 2'b10, 2'b00, 3, 0, 2'b00, 2'b00, 2'b01, {5'b00000, 5'b00001});
    add(1, 5'b00100, 2'b00, 2'b10, 2'b01, 4, 0, 2'b00, 2'b00, 2'b01, {5'b00000, 5'b00001});
    add(1, 5'b00101, 2'b00, 2'b10, 2'b01, 4, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b00001});
    add(0, 5'b00000, 2'b01, 2'b10, 2'b00, 3, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b00010});
    add(0, 5'b00000, 2'b01, 2'b10, 2'b00, 2, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b00011});
    add(0, 5'b00000, 2'b01, 2'b10, 2'b00, 1, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b00100});
    add(0, 5'b00000, 2'b01, 2'b11, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, {5'b00000, 5'b00000});
    add(1, 5'b00111, 2'b00, 2'b10, 2'b00, 1, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b00111});
    add(1, 5'b01000, 2'b00, 2'b10, 2'b00, 2, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b00111});
    add(1, 5'b01001, 2'b00, 2'b10, 2'b00, 3, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b00111});
    add(1, 5'b01010, 2'b00, 2'b10, 2'b01, 4, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b00111});
    add(1, 5'b01111, 2'b01, 2'b10, 2'b00, 3, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b01000});
    add(0, 5'b00000, 2'b01, 2'b10, 2'b00, 2, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b01001});
    add(0, 5'b00000, 2'b01, 2'b10, 2'b00, 1, 0, 2'b01, 2'b00, 2'b01, {5'b00000, 5'b01010});
    add(0, 5'b00000, 2'b01, 2'b11, 2'b00, 0, 0, 2'b01, 2'b00, 2'b00, {5'b00000, 5'b00000});
    add(1, 5'b11001, 2'b10, 2'b01, 2'b00, 0, 1, 2'b01, 2'b10, 2'b10, {5'b11001, 5'b00000});

    foreach (tbl[i]) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0);
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].e_empty));
      chk($sformatf("vec%0d_full", i),  32'(full),  32'(tbl[i].e_full));
      chk($sformatf("vec%0d_count0", i), 32'(count[2:0]), 32'(tbl[i].e_c0));
      chk($sformatf("vec%0d_count1", i), 32'(count[5:3]), 32'(tbl[i].e_c1));
      chk($sformatf("vec%0d_ovf", i),   32'(ovf),   32'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_udf", i),   32'(udf),   32'(tbl[i].e_udf));
      if (tbl[i].mask[0]) chk($sformatf("vec%0d_dout0", i), 32'(dout[4:0]), 32'(tbl[i].e_dout[4:0]));
      if (tbl[i].mask[1]) chk($sformatf("vec%0d_dout1", i), 32'(dout[9:5]), 32'(tbl[i].e_dout[9:5]));
      check_model($sformatf("vec%0d_model", i));
    end

    // Reset mid-operation with a write pending: everything is discarded.
    step(1, 5'b00001, 2'b00, 1'b0);
    step(1, 5'b00010, 2'b00, 1'b0);
    step(1, 5'b00011, 2'b00, 1'b0);
    chk("pre_rst_count0", 32'(count[2:0]), 32'd3);
    step(1, 5'b00100, 2'b11, 1'b1);
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_full",  32'(full),  32'h0);
    chk("rst_ovf",   32'(ovf),   32'h0);
    chk("rst_udf",   32'(udf),   32'h0);
    step(0, 5'b00000, 2'b00, 1'b0);
    chk("post_rst_empty", 32'(empty), 32'h3);
    check_model("post_rst");

    // Randomized traffic alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 800; i++) begin
      logic       w;
      logic [4:0] d;
      logic [1:0] r;
      logic       rs;
      int         rd_pct;
      rd_pct = ((i / 60) % 2 == 0) ? 20 : 75;
      w  = ($urandom_range(99) < 70);
      d  = 5'($urandom);
      r[0] = ($urandom_range(99) < rd_pct);
      r[1] = ($urandom_range(99) < rd_pct);
      rs = ($urandom_range(199) == 0);
      step(w, d, r, rs);
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
